decode_issue_queue: RTL and testbench
=====================================

DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries; power of two, minimum 4.
REQ-002 SHALL have parameter AFULL_MARGIN, default 2, free entries left when almostFull_o asserts.
REQ-003 SHALL have parameters addressSize 64, opcodeWidth 6, XxoOpcodeWidth 10, regWidth 5, immWidth 24, formatIndexRange 5.
REQ-004 clock_i  input  1  single clock; all state on posedge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 enable_i  input  1  decoded instruction valid this cycle (push request).
REQ-007 instructionAddress_i  input  64  instruction address.
REQ-008 opcode_i / xOpcode_i / xOpcodeEnable_i  input  6 / 10 / 1  primary opcode, extended opcode, extended-opcode valid.
REQ-009 instructionFormat_i  input  5  format code (INVALID=0 ... Z23=25).
REQ-010 imm_i / immEnable_i  input  24 / 1  immediate and its valid.
REQ-011 reg1_i, reg2_i, reg3_i  input  5 each  register indices; reg1Enable_i..reg3Enable_i 1 each; reg1Use_i..reg3Use_i 2 each.
REQ-012 reg3IsImmediate_i, reg2ValOrZero_i, bit1_i, bit2_i, bit1Enable_i, bit2Enable_i  input  1 each  decode flags.
REQ-013 functionalUnitCode_i  input  3  target functional unit.
REQ-014 flush_i  input  1  discard all queued entries (branch redirect).
REQ-015 issueReady_i  input  1  issue stage accepts head entry this cycle.
REQ-016 valid_o  output  1  head entry valid.
REQ-017 every *_i bundle field of REQ-007..REQ-013 SHALL have a matching *_o output of identical width carrying the head entry.
REQ-018 full_o, empty_o, almostFull_o  output  1 each  occupancy flags; count_o  output  log2(DEPTH)+1  occupancy.

Function
REQ-019 Push SHALL occur when enable_i=1 and (count<DEPTH or pop same cycle); entry stored at write pointer.
REQ-020 Pop SHALL occur when valid_o=1 and issueReady_i=1; read pointer advances.
REQ-021 Head outputs SHALL be driven from registered storage, first-word-fall-through; entry pushed in cycle N visible with valid_o=1 in cycle N+1 when queue was empty.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL be count+push-pop, never outside 0..DEPTH.
REQ-023 Full with simultaneous push and pop SHALL accept push; count unchanged.
REQ-024 Empty with simultaneous enable_i and issueReady_i SHALL enqueue only (no bypass); valid_o rises next cycle.
REQ-025 enable_i while full and no pop SHALL drop the incoming instruction; stored entries unchanged.
REQ-026 flush_i SHALL take priority over push and pop: next cycle count=0, pointers=0, valid_o=0; same-cycle push is discarded.
REQ-027 full_o = (count==DEPTH); empty_o = (count==0); almostFull_o = (count >= DEPTH-AFULL_MARGIN); all derived from registered count.
REQ-028 valid_o SHALL equal !empty_o; head *_o fields are don't-care but stable while valid_o=0.

Reset
REQ-029 reset_i asserted SHALL immediately clear pointers, count and valid_o; empty_o=1, full_o=0, almostFull_o=0, count_o=0, all head *_o fields 0.
REQ-030 Reset mid-operation SHALL discard all entries; first push after deassertion lands in slot 0.

Configuration
REQ-031 Macro DECODE_QUEUE_STATS_EN defined: SHALL add outputs overflow_o (1, sticky, set on REQ-025 drop, cleared by reset only) and dropCount_o (16, saturating at 16'hFFFF, incremented per dropped push).
REQ-032 Macro undefined: those ports and their counters SHALL not exist; drop behaviour unchanged.

Structure
REQ-033 Format codes (INVALID..Z23), functional-unit codes and bundle widths SHALL live in shared package decode_pkg, also used by the decode stages.
REQ-034 Storage array SHALL be sub-module decode_queue_storage (DEPTH x bundle width, one write port, one async read port); pointer/count control stays in top level.

Verification
REQ-035 Reset then push D-format entry (addr 0x1000, imm 0x000010) -> next cycle valid_o=1, instructionAddress_o=0x1000, imm_o=0x000010, count_o=1.
REQ-036 Push 4 entries with issueReady_i=0 -> full_o=1, almostFull_o=1 after 2nd push; 5th push dropped; pops return addr 0x1000,0x1004,0x1008,0x100C in order.
REQ-037 Full queue, enable_i=1 and issueReady_i=1 same cycle -> count_o stays 4, new entry emerges after 3 further pops.
REQ-038 3 entries queued, flush_i=1 with enable_i=1 -> next cycle count_o=0, valid_o=0, empty_o=1.
REQ-039 Stream 10 pushes/pops at full rate -> pointers wrap, order preserved, count_o never exceeds 1.
REQ-040 DECODE_QUEUE_STATS_EN defined, 3 pushes into full queue -> dropCount_o=3, overflow_o=1 until reset_i.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: bundle field widths, format and functional-unit codes,
// and the packed bundle carried from decode into the issue queue.
package decode_pkg;

   localparam int addressSize      = 64;
   localparam int opcodeWidth      = 6;
   localparam int XxoOpcodeWidth   = 10;
   localparam int regWidth         = 5;
   localparam int immWidth         = 24;
   localparam int formatIndexRange = 5;
   localparam int regUseWidth      = 2;
   localparam int fuCodeWidth      = 3;

   typedef enum logic [formatIndexRange-1:0] {
      FMT_INVALID = 5'd0,
      FMT_I       = 5'd1,
      FMT_B       = 5'd2,
      FMT_SC      = 5'd3,
      FMT_D       = 5'd4,
      FMT_DS      = 5'd5,
      FMT_DQ      = 5'd6,
      FMT_DX      = 5'd7,
      FMT_X       = 5'd8,
      FMT_XL      = 5'd9,
      FMT_XFX     = 5'd10,
      FMT_XFL     = 5'd11,
      FMT_XX1     = 5'd12,
      FMT_XX2     = 5'd13,
      FMT_XX3     = 5'd14,
      FMT_XX4     = 5'd15,
      FMT_XS      = 5'd16,
      FMT_XO      = 5'd17,
      FMT_A       = 5'd18,
      FMT_M       = 5'd19,
      FMT_MD      = 5'd20,
      FMT_MDS     = 5'd21,
      FMT_VA      = 5'd22,
      FMT_VX      = 5'd23,
      FMT_Z22     = 5'd24,
      FMT_Z23     = 5'd25
   } insn_format_e;

   typedef enum logic [fuCodeWidth-1:0] {
      FU_NONE   = 3'd0,
      FU_ALU    = 3'd1,
      FU_BRANCH = 3'd2,
      FU_LSU    = 3'd3,
      FU_MUL    = 3'd4,
      FU_FPU    = 3'd5,
      FU_VEC    = 3'd6,
      FU_SYS    = 3'd7
   } func_unit_e;

   typedef struct packed {
      logic [addressSize-1:0]      instructionAddress;
      logic [opcodeWidth-1:0]      opcode;
      logic [XxoOpcodeWidth-1:0]   xOpcode;
      logic                        xOpcodeEnable;
      logic [formatIndexRange-1:0] instructionFormat;
      logic [immWidth-1:0]         imm;
      logic                        immEnable;
      logic [regWidth-1:0]         reg1;
      logic [regWidth-1:0]         reg2;
      logic [regWidth-1:0]         reg3;
      logic                        reg1Enable;
      logic                        reg2Enable;
      logic                        reg3Enable;
      logic [regUseWidth-1:0]      reg1Use;
      logic [regUseWidth-1:0]      reg2Use;
      logic [regUseWidth-1:0]      reg3Use;
      logic                        reg3IsImmediate;
      logic                        reg2ValOrZero;
      logic                        bit1;
      logic                        bit2;
      logic                        bit1Enable;
      logic                        bit2Enable;
      logic [fuCodeWidth-1:0]      functionalUnitCode;
   } issue_bundle_t;

endpackage

// File: rtl/decode_issue_queue_if.sv
// Decode-to-issue queue port bundle: push side from decode, head side to issue.
// slave = queue, master = the decode/issue pair driving it.
interface decode_issue_queue_if #(parameter int DEPTH = 4);
   import decode_pkg::*;

   logic                        enable_i;
   logic [addressSize-1:0]      instructionAddress_i;
   logic [opcodeWidth-1:0]      opcode_i;
   logic [XxoOpcodeWidth-1:0]   xOpcode_i;
   logic                        xOpcodeEnable_i;
   logic [formatIndexRange-1:0] instructionFormat_i;
   logic [immWidth-1:0]         imm_i;
   logic                        immEnable_i;
   logic [regWidth-1:0]         reg1_i, reg2_i, reg3_i;
   logic                        reg1Enable_i, reg2Enable_i, reg3Enable_i;
   logic [regUseWidth-1:0]      reg1Use_i, reg2Use_i, reg3Use_i;
   logic                        reg3IsImmediate_i, reg2ValOrZero_i;
   logic                        bit1_i, bit2_i, bit1Enable_i, bit2Enable_i;
   logic [fuCodeWidth-1:0]      functionalUnitCode_i;
   logic                        flush_i;
   logic                        issueReady_i;

   logic                        valid_o;
   logic [addressSize-1:0]      instructionAddress_o;
   logic [opcodeWidth-1:0]      opcode_o;
   logic [XxoOpcodeWidth-1:0]   xOpcode_o;
   logic                        xOpcodeEnable_o;
   logic [formatIndexRange-1:0] instructionFormat_o;
   logic [immWidth-1:0]         imm_o;
   logic                        immEnable_o;
   logic [regWidth-1:0]         reg1_o, reg2_o, reg3_o;
   logic                        reg1Enable_o, reg2Enable_o, reg3Enable_o;
   logic [regUseWidth-1:0]      reg1Use_o, reg2Use_o, reg3Use_o;
   logic                        reg3IsImmediate_o, reg2ValOrZero_o;
   logic                        bit1_o, bit2_o, bit1Enable_o, bit2Enable_o;
   logic [fuCodeWidth-1:0]      functionalUnitCode_o;
   logic                        full_o, empty_o, almostFull_o;
   logic [$clog2(DEPTH):0]      count_o;

   modport slave (
      input  enable_i, instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i,
             instructionFormat_i, imm_i, immEnable_i, reg1_i, reg2_i, reg3_i,
             reg1Enable_i, reg2Enable_i, reg3Enable_i, reg1Use_i, reg2Use_i, reg3Use_i,
             reg3IsImmediate_i, reg2ValOrZero_i, bit1_i, bit2_i, bit1Enable_i, bit2Enable_i,
             functionalUnitCode_i, flush_i, issueReady_i,
      output valid_o, instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o,
             instructionFormat_o, imm_o, immEnable_o, reg1_o, reg2_o, reg3_o,
             reg1Enable_o, reg2Enable_o, reg3Enable_o, reg1Use_o, reg2Use_o, reg3Use_o,
             reg3IsImmediate_o, reg2ValOrZero_o, bit1_o, bit2_o, bit1Enable_o, bit2Enable_o,
             functionalUnitCode_o, full_o, empty_o, almostFull_o, count_o
   );

   modport master (
      output enable_i, instructionAddress_i, opcode_i, xOpcode_i, xOpcodeEnable_i,
             instructionFormat_i, imm_i, immEnable_i, reg1_i, reg2_i, reg3_i,
             reg1Enable_i, reg2Enable_i, reg3Enable_i, reg1Use_i, reg2Use_i, reg3Use_i,
             reg3IsImmediate_i, reg2ValOrZero_i, bit1_i, bit2_i, bit1Enable_i, bit2Enable_i,
             functionalUnitCode_i, flush_i, issueReady_i,
      input  valid_o, instructionAddress_o, opcode_o, xOpcode_o, xOpcodeEnable_o,
             instructionFormat_o, imm_o, immEnable_o, reg1_o, reg2_o, reg3_o,
             reg1Enable_o, reg2Enable_o, reg3Enable_o, reg1Use_o, reg2Use_o, reg3Use_o,
             reg3IsImmediate_o, reg2ValOrZero_o, bit1_o, bit2_o, bit1Enable_o, bit2Enable_o,
             functionalUnitCode_o, full_o, empty_o, almostFull_o, count_o
   );
endinterface

// File: rtl/decode_queue_storage.sv
// Issue-queue entry array: one synchronous write port, one asynchronous read port.
// Cleared on reset so the head fields read zero out of reset.
module decode_queue_storage #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]         rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/decode_issue_queue.sv
// First-word-fall-through queue between decode and issue; DEPTH must be a power of two.
// Optional drop statistics (overflow_o, dropCount_o) under DECODE_QUEUE_STATS_EN.
module decode_issue_queue
   import decode_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   decode_issue_queue_if.slave  q_if
`ifdef DECODE_QUEUE_STATS_EN
   ,
   output logic                 overflow_o,
   output logic [15:0]          dropCount_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             is_full, is_empty, push, pop;
   issue_bundle_t    wr_bundle, head;

   assign is_full  = (count_q == FULL_LVL);
   assign is_empty = (count_q == '0);
   assign pop      = !is_empty && q_if.issueReady_i;
   // A full queue still takes a push when the head leaves in the same cycle.
   assign push     = q_if.enable_i && (!is_full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (q_if.flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_bundle.instructionAddress = q_if.instructionAddress_i;
   assign wr_bundle.opcode             = q_if.opcode_i;
   assign wr_bundle.xOpcode            = q_if.xOpcode_i;
   assign wr_bundle.xOpcodeEnable      = q_if.xOpcodeEnable_i;
   assign wr_bundle.instructionFormat  = q_if.instructionFormat_i;
   assign wr_bundle.imm                = q_if.imm_i;
   assign wr_bundle.immEnable          = q_if.immEnable_i;
   assign wr_bundle.reg1               = q_if.reg1_i;
   assign wr_bundle.reg2               = q_if.reg2_i;
   assign wr_bundle.reg3               = q_if.reg3_i;
   assign wr_bundle.reg1Enable         = q_if.reg1Enable_i;
   assign wr_bundle.reg2Enable         = q_if.reg2Enable_i;
   assign wr_bundle.reg3Enable         = q_if.reg3Enable_i;
   assign wr_bundle.reg1Use            = q_if.reg1Use_i;
   assign wr_bundle.reg2Use            = q_if.reg2Use_i;
   assign wr_bundle.reg3Use            = q_if.reg3Use_i;
   assign wr_bundle.reg3IsImmediate    = q_if.reg3IsImmediate_i;
   assign wr_bundle.reg2ValOrZero      = q_if.reg2ValOrZero_i;
   assign wr_bundle.bit1               = q_if.bit1_i;
   assign wr_bundle.bit2               = q_if.bit2_i;
   assign wr_bundle.bit1Enable         = q_if.bit1Enable_i;
   assign wr_bundle.bit2Enable         = q_if.bit2Enable_i;
   assign wr_bundle.functionalUnitCode = q_if.functionalUnitCode_i;

   decode_queue_storage #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(issue_bundle_t))
   ) u_storage (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .wr_en_i   (push && !q_if.flush_i),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_bundle),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (head)
   );

   assign q_if.valid_o              = !is_empty;
   assign q_if.empty_o              = is_empty;
   assign q_if.full_o               = is_full;
   assign q_if.almostFull_o         = (count_q >= AFULL_LVL);
   assign q_if.count_o              = count_q;
   assign q_if.instructionAddress_o = head.instructionAddress;
   assign q_if.opcode_o             = head.opcode;
   assign q_if.xOpcode_o            = head.xOpcode;
   assign q_if.xOpcodeEnable_o      = head.xOpcodeEnable;
   assign q_if.instructionFormat_o  = head.instructionFormat;
   assign q_if.imm_o                = head.imm;
   assign q_if.immEnable_o          = head.immEnable;
   assign q_if.reg1_o               = head.reg1;
   assign q_if.reg2_o               = head.reg2;
   assign q_if.reg3_o               = head.reg3;
   assign q_if.reg1Enable_o         = head.reg1Enable;
   assign q_if.reg2Enable_o         = head.reg2Enable;
   assign q_if.reg3Enable_o         = head.reg3Enable;
   assign q_if.reg1Use_o            = head.reg1Use;
   assign q_if.reg2Use_o            = head.reg2Use;
   assign q_if.reg3Use_o            = head.reg3Use;
   assign q_if.reg3IsImmediate_o    = head.reg3IsImmediate;
   assign q_if.reg2ValOrZero_o      = head.reg2ValOrZero;
   assign q_if.bit1_o               = head.bit1;
   assign q_if.bit2_o               = head.bit2;
   assign q_if.bit1Enable_o         = head.bit1Enable;
   assign q_if.bit2Enable_o         = head.bit2Enable;
   assign q_if.functionalUnitCode_o = head.functionalUnitCode;

`ifdef DECODE_QUEUE_STATS_EN
   logic        drop;
   logic        overflow_q;
   logic [15:0] drop_cnt_q;

   // A flush in the same cycle discards the push anyway, so it is not counted as a drop.
   assign drop = q_if.enable_i && is_full && !pop && !q_if.flush_i;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign overflow_o  = overflow_q;
   assign dropCount_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed scenarios plus random traffic
// against a queue-based reference model. Stats checks apply when DECODE_QUEUE_STATS_EN is defined.
module tb_decode_issue_queue;
   import decode_pkg::*;

   localparam int DEPTH        = 4;
   localparam int AFULL_MARGIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   decode_issue_queue_if #(.DEPTH(DEPTH)) q_if ();

`ifdef DECODE_QUEUE_STATS_EN
   logic        overflow;
   logic [15:0] drop_count;
   logic        m_overflow = 1'b0;
   int          m_drops = 0;
`endif

   decode_issue_queue #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .q_if    (q_if)
`ifdef DECODE_QUEUE_STATS_EN
      ,
      .overflow_o  (overflow),
      .dropCount_o (drop_count)
`endif
   );

   always #5 clk = ~clk;

   issue_bundle_t mq[$];
   logic          drv_en, drv_rdy, drv_fl;
   issue_bundle_t drv_b;

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic issue_bundle_t rand_bundle();
      issue_bundle_t b;
      b.instructionAddress = {$urandom(), $urandom()};
      b.opcode             = opcodeWidth'($urandom());
      b.xOpcode            = XxoOpcodeWidth'($urandom());
      b.xOpcodeEnable      = 1'($urandom());
      b.instructionFormat  = formatIndexRange'($urandom_range(0, 25));
      b.imm                = immWidth'($urandom());
      b.immEnable          = 1'($urandom());
      b.reg1               = regWidth'($urandom());
      b.reg2               = regWidth'($urandom());
      b.reg3               = regWidth'($urandom());
      b.reg1Enable         = 1'($urandom());
      b.reg2Enable         = 1'($urandom());
      b.reg3Enable         = 1'($urandom());
      b.reg1Use            = regUseWidth'($urandom());
      b.reg2Use            = regUseWidth'($urandom());
      b.reg3Use            = regUseWidth'($urandom());
      b.reg3IsImmediate    = 1'($urandom());
      b.reg2ValOrZero      = 1'($urandom());
      b.bit1               = 1'($urandom());
      b.bit2               = 1'($urandom());
      b.bit1Enable         = 1'($urandom());
      b.bit2Enable         = 1'($urandom());
      b.functionalUnitCode = fuCodeWidth'($urandom());
      return b;
   endfunction

   function automatic issue_bundle_t d_form(input logic [63:0] addr, input logic [23:0] imm);
      issue_bundle_t b;
      b = rand_bundle();
      b.instructionAddress = addr;
      b.imm                = imm;
      b.immEnable          = 1'b1;
      b.instructionFormat  = FMT_D;
      return b;
   endfunction

   function automatic issue_bundle_t dut_head();
      issue_bundle_t b;
      b.instructionAddress = q_if.instructionAddress_o;
      b.opcode             = q_if.opcode_o;
      b.xOpcode            = q_if.xOpcode_o;
      b.xOpcodeEnable      = q_if.xOpcodeEnable_o;
      b.instructionFormat  = q_if.instructionFormat_o;
      b.imm                = q_if.imm_o;
      b.immEnable          = q_if.immEnable_o;
      b.reg1               = q_if.reg1_o;
      b.reg2               = q_if.reg2_o;
      b.reg3               = q_if.reg3_o;
      b.reg1Enable         = q_if.reg1Enable_o;
      b.reg2Enable         = q_if.reg2Enable_o;
      b.reg3Enable         = q_if.reg3Enable_o;
      b.reg1Use            = q_if.reg1Use_o;
      b.reg2Use            = q_if.reg2Use_o;
      b.reg3Use            = q_if.reg3Use_o;
      b.reg3IsImmediate    = q_if.reg3IsImmediate_o;
      b.reg2ValOrZero      = q_if.reg2ValOrZero_o;
      b.bit1               = q_if.bit1_o;
      b.bit2               = q_if.bit2_o;
      b.bit1Enable         = q_if.bit1Enable_o;
      b.bit2Enable         = q_if.bit2Enable_o;
      b.functionalUnitCode = q_if.functionalUnitCode_o;
      return b;
   endfunction

   task automatic set_in(input logic en, input logic rdy, input logic fl, input issue_bundle_t b);
      drv_en = en; drv_rdy = rdy; drv_fl = fl; drv_b = b;
      q_if.enable_i             = en;
      q_if.issueReady_i         = rdy;
      q_if.flush_i              = fl;
      q_if.instructionAddress_i = b.instructionAddress;
      q_if.opcode_i             = b.opcode;
      q_if.xOpcode_i            = b.xOpcode;
      q_if.xOpcodeEnable_i      = b.xOpcodeEnable;
      q_if.instructionFormat_i  = b.instructionFormat;
      q_if.imm_i                = b.imm;
      q_if.immEnable_i          = b.immEnable;
      q_if.reg1_i               = b.reg1;
      q_if.reg2_i               = b.reg2;
      q_if.reg3_i               = b.reg3;
      q_if.reg1Enable_i         = b.reg1Enable;
      q_if.reg2Enable_i         = b.reg2Enable;
      q_if.reg3Enable_i         = b.reg3Enable;
      q_if.reg1Use_i            = b.reg1Use;
      q_if.reg2Use_i            = b.reg2Use;
      q_if.reg3Use_i            = b.reg3Use;
      q_if.reg3IsImmediate_i    = b.reg3IsImmediate;
      q_if.reg2ValOrZero_i      = b.reg2ValOrZero;
      q_if.bit1_i               = b.bit1;
      q_if.bit2_i               = b.bit2;
      q_if.bit1Enable_i         = b.bit1Enable;
      q_if.bit2Enable_i         = b.bit2Enable;
      q_if.functionalUnitCode_i = b.functionalUnitCode;
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = mq.size();
      check_val({tag, ".valid"}, q_if.valid_o, sz != 0);
      check_val({tag, ".empty"}, q_if.empty_o, sz == 0);
      check_val({tag, ".full"}, q_if.full_o, sz == DEPTH);
      check_val({tag, ".afull"}, q_if.almostFull_o, sz >= DEPTH - AFULL_MARGIN);
      check_val({tag, ".count"}, q_if.count_o, 256'(sz));
      if (sz != 0) check_val({tag, ".head"}, 256'(dut_head()), 256'(mq[0]));
`ifdef DECODE_QUEUE_STATS_EN
      check_val({tag, ".overflow"}, overflow, m_overflow);
      check_val({tag, ".dropcnt"}, drop_count, 256'(m_drops));
`endif
   endtask

   // One clock of traffic: the model applies the queue rules to the inputs seen at the edge.
   task automatic step(input string tag);
      bit pop, push;
      @(posedge clk);
      pop  = (mq.size() > 0) && drv_rdy;
      push = drv_en && ((mq.size() < DEPTH) || pop);
      if (drv_fl) begin
         mq.delete();
      end else begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(drv_b);
`ifdef DECODE_QUEUE_STATS_EN
         if (drv_en && !push) begin
            m_overflow = 1'b1;
            if (m_drops < 16'hFFFF) m_drops++;
         end
`endif
      end
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      mq.delete();
`ifdef DECODE_QUEUE_STATS_EN
      m_overflow = 1'b0;
      m_drops    = 0;
`endif
      check_all(tag);
      check_val({tag, ".head0"}, 256'(dut_head()), 256'(0));
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      issue_bundle_t idle;
      idle = '0;
      set_in(1'b0, 1'b0, 1'b0, idle);
      do_reset("reset");

      // single D-format push, visible the following cycle
      set_in(1'b1, 1'b0, 1'b0, d_form(64'h1000, 24'h000010));
      step("push1");
      check_val("d.valid", q_if.valid_o, 1'b1);
      check_val("d.addr", q_if.instructionAddress_o, 64'h1000);
      check_val("d.imm", q_if.imm_o, 24'h000010);
      check_val("d.fmt", q_if.instructionFormat_o, FMT_D);
      check_val("d.count", q_if.count_o, 3'd1);
      set_in(1'b0, 1'b1, 1'b0, idle);
      step("drain1");

      // fill to full, then one dropped push, then ordered pops
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 1'b0, 1'b0, d_form(64'h1000 + 64'(4 * i), 24'(i)));
         step("fill");
         if (i == 1) check_val("fill.afull2", q_if.almostFull_o, 1'b1);
      end
      check_val("fill.full", q_if.full_o, 1'b1);
      set_in(1'b1, 1'b0, 1'b0, d_form(64'h2000, 24'h0));
      step("drop");
      check_val("drop.count", q_if.count_o, 3'd4);
      set_in(1'b0, 1'b1, 1'b0, idle);
      for (int i = 0; i < DEPTH; i++) begin
         check_val("order.addr", q_if.instructionAddress_o, 64'h1000 + 64'(4 * i));
         step("order");
      end
      check_val("order.empty", q_if.empty_o, 1'b1);

      // full queue with push and pop together
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 1'b0, 1'b0, d_form(64'h3000 + 64'(4 * i), 24'(i)));
         step("fill2");
      end
      set_in(1'b1, 1'b1, 1'b0, d_form(64'h4000, 24'h44));
      step("fullpp");
      check_val("fullpp.count", q_if.count_o, 3'd4);
      set_in(1'b0, 1'b1, 1'b0, idle);
      for (int i = 0; i < 3; i++) step("fullpp.pop");
      check_val("fullpp.new", q_if.instructionAddress_o, 64'h4000);
      step("fullpp.last");

      // empty queue with push and ready together: enqueue only
      set_in(1'b1, 1'b1, 1'b0, d_form(64'h4800, 24'h1));
      step("nobypass");
      check_val("nobypass.count", q_if.count_o, 3'd1);
      set_in(1'b0, 1'b1, 1'b0, idle);
      step("nobypass.drain");

      // flush beats a same-cycle push
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 1'b0, d_form(64'h5000 + 64'(4 * i), 24'(i)));
         step("pre_flush");
      end
      set_in(1'b1, 1'b0, 1'b1, d_form(64'h6000, 24'h6));
      step("flush");
      check_val("flush.count", q_if.count_o, 3'd0);
      check_val("flush.valid", q_if.valid_o, 1'b0);
      check_val("flush.empty", q_if.empty_o, 1'b1);

      // full-rate streaming across pointer wrap
      set_in(1'b1, 1'b1, 1'b0, d_form(64'h7000, 24'h0));
      for (int i = 1; i <= 10; i++) begin
         step("stream");
         check_val("stream.cnt_le1", q_if.count_o <= 3'd1, 1'b1);
         set_in(1'b1, 1'b1, 1'b0, d_form(64'h7000 + 64'(4 * i), 24'(i)));
      end
      set_in(1'b0, 1'b1, 1'b0, idle);
      step("stream.drain");

      // reset in the middle of traffic, then a fresh push
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b0, 1'b0, rand_bundle());
         step("pre_rst");
      end
      do_reset("midrst");
      set_in(1'b1, 1'b0, 1'b0, d_form(64'h8000, 24'h8));
      step("postrst");
      check_val("postrst.addr", q_if.instructionAddress_o, 64'h8000);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 4, rand_bundle());
         step("rand");
      end

`ifdef DECODE_QUEUE_STATS_EN
      set_in(1'b0, 1'b0, 1'b0, idle);
      do_reset("stats_rst");
      for (int i = 0; i < DEPTH + 3; i++) begin
         set_in(1'b1, 1'b0, 1'b0, rand_bundle());
         step("stats");
      end
      check_val("stats.drops3", drop_count, 16'd3);
      check_val("stats.ovf", overflow, 1'b1);
      set_in(1'b0, 1'b1, 1'b0, idle);
      for (int i = 0; i < DEPTH; i++) step("stats.drain");
      check_val("stats.sticky", overflow, 1'b1);
      set_in(1'b0, 1'b0, 1'b0, idle);
      do_reset("stats_clr");
      check_val("stats.ovf_clr", overflow, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
